// File: rtl/xps2_rx_pkg.sv
// Shared constants for the PS/2 receiver: register map, STATUS bit positions, frame layout, FSM encoding.
// Used by xps2_rx and its FIFO.
package xps2_rx_pkg;

  localparam logic XPS2_STATUS = 1'b0;
  localparam logic XPS2_DATA   = 1'b1;

  localparam int ST_NEMPTY = 0;
  localparam int ST_OVF    = 1;
  localparam int ST_PERR   = 2;
  localparam int ST_FERR   = 3;

  localparam logic [7:0] XPS2_BREAK = 8'hF0;
  localparam int FRAME_LEN    = 11;
  localparam int PAYLOAD_BITS = FRAME_LEN - 1;  // data, parity and stop follow the start bit

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] count;
    logic       ferr;
    logic       perr;
    logic       ovf;
    logic       nempty;
  } status_t;

  function automatic logic [3:0] sat_count(input int unsigned c);
    return (c > 15) ? 4'd15 : c[3:0];
  endfunction

endpackage

// File: rtl/xps2_rx_if.sv
// picoVersat peripheral bus as seen by xps2_rx: select, read/write, address, write data, read data.
// master = controller side, slave = peripheral side.
interface xps2_rx_if #(
  parameter int DATA_W = 32
) ();
  logic              sel;
  logic              rw;
  logic              addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, rw, addr, data_in, input data_out);
  modport slave  (input sel, rw, addr, data_in, output data_out);
endinterface

// File: rtl/xps2_fifo.sv
// Synchronous scan-code FIFO; FIFO_DEPTH must be a power of two so pointers wrap naturally.
// Latency 1 cycle push-to-visible; a push while full only lands if a pop happens the same cycle.
module xps2_fifo #(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/xps2_rx.sv
// PS/2 device-to-host receiver: sync, 11-bit frame FSM with parity/stop/timeout checks, FIFO, STATUS/DATA regs.
// Pin edge acted on 3 clk later, byte visible 1 cycle after CHECK; no backpressure, full FIFO drops and sets OVF.
// XPS2_BREAK_FILTER_EN: drop 0xF0 and the byte after it so each keypress yields one entry.
module xps2_rx
  import xps2_rx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  xps2_rx_if.slave bus
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]              clk_sync, dat_sync;
  logic                    clk_prev, fall, bit_in;
  state_t                  state, state_nxt;
  logic [3:0]              bit_cnt;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    last_bit, tmo_hit;
  logic                    accept, push, perr_set, ferr_set, ovf_set;
  logic                    ovf, perr, ferr;
  logic                    pop, clr_wr;
  logic [7:0]              fifo_dout;
  logic                    fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_cnt;
  status_t                 st;
  logic [7:0]              status_word;
  logic                    unused_data_in;

  // Idle level of both pins is high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[1];
  assign bit_in   = dat_sync[1];
  assign last_bit = (bit_cnt == 4'(PAYLOAD_BITS - 1));
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fall && !bit_in) state_nxt = S_RECV;
      S_RECV: begin
        if (fall && last_bit) state_nxt = S_CHECK;
        else if (!fall && tmo_hit) state_nxt = S_IDLE;
      end
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      tmo_cnt <= '0;
    end else if (state == S_RECV) begin
      if (fall) begin
        shreg   <= {bit_in, shreg[PAYLOAD_BITS-1:1]};
        bit_cnt <= bit_cnt + 4'd1;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end else begin
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end
  end

`ifdef XPS2_BREAK_FILTER_EN
  logic brk;
  // Any accepted byte while brk is set is the released key's code: drop it and re-arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        brk <= 1'b0;
    else if (accept) brk <= ~brk & (shreg[7:0] == XPS2_BREAK);
  end
`endif

  always_comb begin
    accept   = 1'b0;
    push     = 1'b0;
    perr_set = 1'b0;
    ferr_set = 1'b0;
    if (state == S_CHECK) begin
      perr_set = ~(^shreg[8:0]);
      ferr_set = ~shreg[9];
      accept   = ~perr_set & ~ferr_set;
`ifdef XPS2_BREAK_FILTER_EN
      push     = accept & ~brk & (shreg[7:0] != XPS2_BREAK);
`else
      push     = accept;
`endif
    end
  end

  assign pop     = bus.sel & ~bus.rw & (bus.addr == XPS2_DATA);
  assign clr_wr  = bus.sel & bus.rw & (bus.addr == XPS2_STATUS);
  assign ovf_set = push & fifo_full & ~pop;

  xps2_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (shreg[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Set beats a same-cycle clear so no error event is ever lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovf  <= ovf_set  | (ovf  & ~(clr_wr & bus.data_in[ST_OVF]));
      perr <= perr_set | (perr & ~(clr_wr & bus.data_in[ST_PERR]));
      ferr <= ferr_set | (ferr & ~(clr_wr & bus.data_in[ST_FERR]));
    end
  end

  always_comb begin
    st.count    = sat_count(32'(fifo_cnt));
    st.ferr     = ferr;
    st.perr     = perr;
    st.ovf      = ovf;
    st.nempty   = ~fifo_empty;
    status_word = st;
  end

  assign bus.data_out = (bus.addr == XPS2_DATA) ? (fifo_empty ? '0 : DATA_W'(fifo_dout))
                                                : DATA_W'(status_word);

  assign unused_data_in = ^{bus.data_in[DATA_W-1:4], bus.data_in[ST_NEMPTY]};
endmodule

// File: tb/tb_xps2_rx.sv
// Randomised scoreboard bench for xps2_rx: a PS/2 pin driver plus a queue-based reference model of FIFO and flags.
// Every bus read pushes its expected value; a negedge monitor pops and compares against data_out.
module tb_xps2_rx;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TMO    = 2000;
  localparam int HALF   = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  xps2_rx_if #(.DATA_W(DATA_W)) bus ();

  xps2_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]        mdl_q[$];
  bit                m_ovf, m_perr, m_ferr, m_brk;
  logic [DATA_W-1:0] exp_q[$];
  string             tag_q[$];
  int                tests = 0;
  int                fails = 0;

  function automatic logic [DATA_W-1:0] mdl_status();
    int n;
    n = mdl_q.size();
    return DATA_W'((n > 15 ? 15 : n) * 16 + (m_ferr ? 8 : 0) + (m_perr ? 4 : 0)
                   + (m_ovf ? 2 : 0) + (n > 0 ? 1 : 0));
  endfunction

  function automatic void mdl_reset();
    mdl_q.delete();
    m_ovf = 0; m_perr = 0; m_ferr = 0; m_brk = 0;
  endfunction

  function automatic void mdl_enqueue(input logic [7:0] b);
    if (mdl_q.size() == DEPTH) m_ovf = 1;
    else mdl_q.push_back(b);
  endfunction

  function automatic void mdl_frame(input logic [7:0] b, input bit par, input bit stop);
    int ones;
    ones = $countones(b) + int'(par);
    if (ones % 2 == 0) m_perr = 1;
    if (!stop) m_ferr = 1;
    if (ones % 2 == 1 && stop) begin
`ifdef XPS2_BREAK_FILTER_EN
      if (m_brk) m_brk = 0;
      else if (b == 8'hF0) m_brk = 1;
      else mdl_enqueue(b);
`else
      mdl_enqueue(b);
`endif
    end
  endfunction

  task automatic bus_idle();
    @(posedge clk); #1;
    bus.sel = 0; bus.rw = 0; bus.addr = 0; bus.data_in = '0;
  endtask

  task automatic rd(input logic a, input string tag);
    logic [DATA_W-1:0] e;
    if (a == 1'b0) e = mdl_status();
    else if (mdl_q.size() == 0) e = '0;
    else e = DATA_W'(mdl_q.pop_front());
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    bus.sel = 1; bus.rw = 0; bus.addr = a;
  endtask

  task automatic wr(input logic a, input logic [7:0] v);
    if (a == 1'b0) begin
      if (v[1]) m_ovf = 0;
      if (v[2]) m_perr = 0;
      if (v[3]) m_ferr = 0;
    end
    @(posedge clk); #1;
    bus.sel = 1; bus.rw = 1; bus.addr = a; bus.data_in = DATA_W'(v);
  endtask

  task automatic ps2_bit(input bit b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1;
  endtask

  // probe 1: STATUS on the 4 cycles after the stop-bit fall (NEMPTY must rise on the 4th).
  // probe 2: DATA read timed to pop on the same edge as the push of this frame.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int probe);
    bit par, stop;
    logic [DATA_W-1:0] e;
    logic a;
    par  = ~(^b) ^ bad_par;
    stop = ~bad_stop;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    if (probe == 0) begin
      ps2_bit(stop);
      mdl_frame(b, par, stop);
    end else begin
      ps2_data = stop;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 0;
      for (int k = 1; k <= 4; k++) begin
        if (probe == 2 && k == 3) begin
          e = (mdl_q.size() == 0) ? '0 : DATA_W'(mdl_q.pop_front());
          mdl_frame(b, par, stop);
          a = 1'b1;
        end else begin
          if (probe == 1 && k == 4) mdl_frame(b, par, stop);
          e = mdl_status();
          a = 1'b0;
        end
        exp_q.push_back(e);
        tag_q.push_back($sformatf("probe%0d_cycle%0d", probe, k));
        @(posedge clk); #1;
        bus.sel = 1; bus.rw = 0; bus.addr = a;
      end
      bus_idle();
      repeat (HALF - 5) @(posedge clk);
      #1 ps2_clk = 1;
    end
    ps2_data = 1;
    repeat (8) @(posedge clk);
  endtask

  logic [DATA_W-1:0] mon_exp;
  string             mon_tag;
  always @(negedge clk) begin
    if (bus.sel && !bus.rw) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_read: data_out=%h required no read", bus.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        if (bus.data_out !== mon_exp) begin
          fails++;
          $display("FAIL %s: data_out=%h required %h", mon_tag, bus.data_out, mon_exp);
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 90000 cycles");
    $fatal(1, "watchdog");
  end

  logic [7:0] five[5] = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73};
  int r, n;
  logic [7:0] rb;

  initial begin
    bus.sel = 0; bus.rw = 0; bus.addr = 0; bus.data_in = '0;
    mdl_reset();
    repeat (4) @(posedge clk);
    rd(1'b0, "status_in_reset"); rd(1'b1, "data_in_reset"); bus_idle();
    rst = 1;
    repeat (3) @(posedge clk);
    rd(1'b0, "reset_status"); rd(1'b1, "reset_data"); bus_idle();

    send_frame(8'h69, 0, 0, 1);
    rd(1'b0, "status_69"); rd(1'b1, "data_69"); rd(1'b0, "status_after_pop"); bus_idle();

    send_frame(8'h79, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h79, 0, 0, 0);
    rd(1'b0, "status_brk_seq");
    for (int i = 0; i < 3; i++) rd(1'b1, $sformatf("brk_seq_data%0d", i));
    rd(1'b0, "status_brk_done"); bus_idle();

    send_frame(8'h74, 1, 0, 0);
    rd(1'b0, "status_perr"); wr(1'b0, 8'h04); rd(1'b0, "status_perr_clr"); bus_idle();

    send_frame(8'h33, 0, 1, 0);
    rd(1'b0, "status_ferr"); wr(1'b0, 8'h08); rd(1'b0, "status_ferr_clr"); bus_idle();

    foreach (five[i]) send_frame(five[i], 0, 0, 0);
    rd(1'b0, "status_ovf");
    for (int i = 0; i < 5; i++) rd(1'b1, $sformatf("ovf_data%0d", i));
    wr(1'b0, 8'h02); rd(1'b0, "status_ovf_clr"); bus_idle();

    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 0, 0, 0);
    send_frame(8'h2D, 0, 0, 2);
    for (int i = 0; i < 5; i++) rd(1'b1, $sformatf("fullpop_data%0d", i));
    rd(1'b0, "status_fullpop"); bus_idle();

    ps2_bit(1'b0);
    repeat (4) ps2_bit(1'($urandom_range(0, 1)));
    repeat (TMO + 50) @(posedge clk);
    send_frame(8'h5A, 0, 0, 0);
    rd(1'b0, "status_tmo"); rd(1'b1, "data_tmo"); bus_idle();

    send_frame(8'h55, 0, 0, 0);
    ps2_bit(1'b0);
    repeat (5) ps2_bit(1'($urandom_range(0, 1)));
    rst = 0;
    mdl_reset();
    rd(1'b0, "status_rst_mid"); rd(1'b1, "data_rst_mid"); bus_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    send_frame(8'h7C, 0, 0, 0);
    rd(1'b0, "status_7c"); rd(1'b1, "data_7c"); rd(1'b0, "status_7c_done"); bus_idle();

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        rb = ($urandom_range(0, 4) == 0) ? 8'hF0 : 8'($urandom_range(0, 255));
        send_frame(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 0);
      end else if (r < 80) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) rd(1'b1, "rand_data");
        bus_idle();
      end else if (r < 92) begin
        rd(1'b0, "rand_status"); bus_idle();
      end else begin
        wr(1'($urandom_range(0, 1)), 8'($urandom)); bus_idle();
      end
    end

    rd(1'b0, "final_status");
    while (mdl_q.size() > 0) rd(1'b1, "final_data");
    rd(1'b1, "final_empty_data"); rd(1'b0, "final_status_empty"); bus_idle();

    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_reads: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
